// File: rtl/io_switch_in_pkg.sv
// Shared IO address map and payload types for the memory-mapped IO blocks.
//   IO_ADDR_*  : byte addresses decoded on io_addr (exact match)
//   edge_evt_t : per-bit rise/fall pulse from a debouncer
package io_switch_in_pkg;

    // Output block registers
    localparam logic [31:0] IO_ADDR_SEVEN_SEG = 32'd32;
    localparam logic [31:0] IO_ADDR_LEDS      = 32'd36;

    // Input block registers
    localparam logic [31:0] IO_ADDR_SW_STATE  = 32'd40;
    localparam logic [31:0] IO_ADDR_RISE_EVT  = 32'd44;
    localparam logic [31:0] IO_ADDR_FALL_EVT  = 32'd48;
    localparam logic [31:0] IO_ADDR_IRQ_MASK  = 32'd52;

    typedef struct packed {
        logic rise;
        logic fall;
    } edge_evt_t;

endpackage

// File: rtl/io_switch_in_debounce_bit.sv
// One input bit: synchroniser, sampled debounce window, debounced state and
// single-cycle rise/fall indications aligned with the state change.
//   clk, rst  : clock, async active-high reset
//   tick      : debounce sample strobe (shared across bits)
//   pin       : raw asynchronous pin
//   sw_state  : debounced state (registered)
//   evt_c     : rise/fall of sw_state on the coming edge (combinational)
module io_debounce_bit
    import io_switch_in_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_SAMPLES  = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      tick,
    input  logic      pin,
    output logic      sw_state,
    output edge_evt_t evt_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    // Only the older DB_SAMPLES-1 samples are stored; the newest comes from the synchroniser.
    logic [DB_SAMPLES-2:0]  window_q;
    logic [DB_SAMPLES-1:0]  window_next_c;
    logic                   state_next_c;

    // Synchroniser chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
        end
    end

    // Window shift and debounced state decision
    always_comb begin
        window_next_c = {window_q, sync_q[SYNC_STAGES-1]};
        state_next_c  = sw_state;
        if (tick) begin
            if (&window_next_c) begin
                state_next_c = 1'b1;
            end else if (~|window_next_c) begin
                state_next_c = 1'b0;
            end
        end
        evt_c.rise = state_next_c & ~sw_state;
        evt_c.fall = ~state_next_c & sw_state;
    end

    // Window and state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window_q <= '0;
            sw_state <= 1'b0;
        end else if (tick) begin
            window_q <= window_next_c[DB_SAMPLES-2:0];
            sw_state <= state_next_c;
        end
    end

endmodule

// File: rtl/io_switch_in.sv
// Read side of the memory-mapped IO space: debounced switches, sticky W1C
// edge events, interrupt mask and a single registered level interrupt.
//   clk, rst    : clock, async active-high reset
//   sw_in       : raw switch/button pins (asynchronous)
//   io_addr     : byte address from core
//   io_data_in  : write data
//   io_w_en     : single-cycle write strobe
//   io_data_out : read data, combinational from io_addr
//   irq         : registered level interrupt
module io_switch_in
    import io_switch_in_pkg::*;
#(
    parameter int unsigned IO_DEPTH    = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TICK_DIV    = 50000,
    parameter int unsigned DB_SAMPLES  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IO_DEPTH-1:0] sw_in,
    input  logic [31:0]         io_addr,
    input  logic [IO_DEPTH-1:0] io_data_in,
    input  logic                io_w_en,
    output logic [IO_DEPTH-1:0] io_data_out,
    output logic                irq
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0]    tick_cnt;
    logic                tick_c;
    logic [IO_DEPTH-1:0] sw_state;
    logic [IO_DEPTH-1:0] rise_set_c;
    logic [IO_DEPTH-1:0] fall_set_c;
    logic [IO_DEPTH-1:0] rise_evt;
    logic [IO_DEPTH-1:0] fall_evt;
    logic [IO_DEPTH-1:0] irq_mask;
    logic [IO_DEPTH-1:0] rise_evt_next_c;
    logic [IO_DEPTH-1:0] fall_evt_next_c;
    logic [IO_DEPTH-1:0] irq_mask_next_c;
    logic                irq_next_c;
    logic                wr_rise_c;
    logic                wr_fall_c;
    logic                wr_mask_c;
    edge_evt_t           evt_c [IO_DEPTH];

    // Shared debounce sample strobe
    assign tick_c = (tick_cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick_c) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    // Per-bit conditioning
    for (genvar i = 0; i < int'(IO_DEPTH); i++) begin : g_bit
        io_debounce_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_SAMPLES  (DB_SAMPLES)
        ) u_db (
            .clk      (clk),
            .rst      (rst),
            .tick     (tick_c),
            .pin      (sw_in[i]),
            .sw_state (sw_state[i]),
            .evt_c    (evt_c[i])
        );
        assign rise_set_c[i] = evt_c[i].rise;
        assign fall_set_c[i] = evt_c[i].fall;
    end

    // Event/mask next state; an edge set wins over a same-cycle W1C clear
    always_comb begin
        wr_rise_c       = io_w_en && (io_addr == IO_ADDR_RISE_EVT);
        wr_fall_c       = io_w_en && (io_addr == IO_ADDR_FALL_EVT);
        wr_mask_c       = io_w_en && (io_addr == IO_ADDR_IRQ_MASK);
        rise_evt_next_c = rise_evt;
        fall_evt_next_c = fall_evt;
        irq_mask_next_c = irq_mask;
        if (wr_rise_c) begin
            rise_evt_next_c = rise_evt & ~io_data_in;
        end
        if (wr_fall_c) begin
            fall_evt_next_c = fall_evt & ~io_data_in;
        end
        if (wr_mask_c) begin
            irq_mask_next_c = io_data_in;
        end
        rise_evt_next_c = rise_evt_next_c | rise_set_c;
        fall_evt_next_c = fall_evt_next_c | fall_set_c;
        irq_next_c      = |((rise_evt_next_c | fall_evt_next_c) & irq_mask_next_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_evt <= '0;
            fall_evt <= '0;
            irq_mask <= '0;
            irq      <= 1'b0;
        end else begin
            rise_evt <= rise_evt_next_c;
            fall_evt <= fall_evt_next_c;
            irq_mask <= irq_mask_next_c;
            irq      <= irq_next_c;
        end
    end

    // Side-effect-free read mux
    always_comb begin
        io_data_out = '0;
        case (io_addr)
            IO_ADDR_SW_STATE: io_data_out = sw_state;
            IO_ADDR_RISE_EVT: io_data_out = rise_evt;
            IO_ADDR_FALL_EVT: io_data_out = fall_evt;
            IO_ADDR_IRQ_MASK: io_data_out = irq_mask;
            default:          io_data_out = '0;
        endcase
    end

endmodule
